// File: rtl/neander_pkg.sv
// Shared encodings for the Neander control unit: ISA opcodes, ULA operations,
// FSM states and datapath mux selects.
package neander_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_STA = 4'h1,
    OP_LDA = 4'h2,
    OP_ADD = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_NOT = 4'h6,
    OP_JMP = 4'h8,
    OP_JN  = 4'h9,
    OP_JZ  = 4'hA,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ULA_ADD   = 3'b000,
    ULA_AND   = 3'b001,
    ULA_OR    = 3'b010,
    ULA_NOT   = 3'b011,
    ULA_PASSY = 3'b100
  } ula_op_e;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3, S_A4, S_A5, S_EX,
    S_S0, S_S1, S_J, S_SK, S_NT, S_H
  } state_e;

  localparam logic REM_SEL_PC  = 1'b0;
  localparam logic REM_SEL_RDM = 1'b1;
  localparam logic RDM_SEL_MEM = 1'b0;
  localparam logic RDM_SEL_AC  = 1'b1;

  // LDA moves the fetched operand straight into AC, hence PASSY.
  function automatic logic [2:0] ula_for_op(input logic [3:0] op);
    logic [2:0] sel;
    sel = ULA_PASSY;
    case (op)
      OP_ADD:  sel = ULA_ADD;
      OP_AND:  sel = ULA_AND;
      OP_OR:   sel = ULA_OR;
      default: sel = ULA_PASSY;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/neander_control.sv
// Moore control FSM for the Neander datapath: fetch, decode and execute of the
// full ISA, with every strobe forced low while reset is held.
module neander_control
  import neander_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       flag_n,
  input  logic       flag_z,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       rem_load,
  output logic       rem_sel,
  output logic       rdm_load,
  output logic       rdm_sel,
  output logic       mem_write,
  output logic       ri_load,
  output logic       ac_load,
  output logic [2:0] sel_ula,
  output logic       nz_load,
  output logic       instr_done,
  output logic       halted
);

  state_e     state;
  state_e     state_next;
  logic       pc_load_d;
  logic       pc_inc_d;
  logic       rem_load_d;
  logic       rem_sel_d;
  logic       rdm_load_d;
  logic       rdm_sel_d;
  logic       mem_write_d;
  logic       ri_load_d;
  logic       ac_load_d;
  logic [2:0] sel_ula_d;
  logic       nz_load_d;
  logic       instr_done_d;
  logic       halted_d;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_F0;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = S_F0;
    pc_load_d    = 1'b0;
    pc_inc_d     = 1'b0;
    rem_load_d   = 1'b0;
    rem_sel_d    = REM_SEL_PC;
    rdm_load_d   = 1'b0;
    rdm_sel_d    = RDM_SEL_MEM;
    mem_write_d  = 1'b0;
    ri_load_d    = 1'b0;
    ac_load_d    = 1'b0;
    sel_ula_d    = ULA_ADD;
    nz_load_d    = 1'b0;
    instr_done_d = 1'b0;
    halted_d     = 1'b0;

    case (state)
      S_F0: begin
        rem_load_d = 1'b1;
        rem_sel_d  = REM_SEL_PC;
        state_next = S_F1;
      end
      S_F1: state_next = S_F2;
      S_F2: begin
        rdm_load_d = 1'b1;
        rdm_sel_d  = RDM_SEL_MEM;
        pc_inc_d   = 1'b1;
        state_next = S_F3;
      end
      S_F3: begin
        ri_load_d  = 1'b1;
        state_next = S_DEC;
      end
      // Unknown opcodes fall through to the NOP path and finish here.
      S_DEC: begin
        case (opcode)
          OP_NOT: state_next = S_NT;
          OP_HLT: state_next = S_H;
          OP_JN:  state_next = flag_n ? S_A0 : S_SK;
          OP_JZ:  state_next = flag_z ? S_A0 : S_SK;
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP:
            state_next = S_A0;
          default: begin
            instr_done_d = 1'b1;
            state_next   = S_F0;
          end
        endcase
      end
      S_A0: begin
        rem_load_d = 1'b1;
        rem_sel_d  = REM_SEL_PC;
        state_next = S_A1;
      end
      S_A1: state_next = S_A2;
      S_A2: begin
        rdm_load_d = 1'b1;
        rdm_sel_d  = RDM_SEL_MEM;
        pc_inc_d   = 1'b1;
        case (opcode)
          OP_JMP, OP_JN, OP_JZ: state_next = S_J;
          default:              state_next = S_A3;
        endcase
      end
      S_A3: begin
        rem_load_d = 1'b1;
        rem_sel_d  = REM_SEL_RDM;
        state_next = (opcode == OP_STA) ? S_S0 : S_A4;
      end
      S_A4: state_next = S_A5;
      S_A5: begin
        rdm_load_d = 1'b1;
        rdm_sel_d  = RDM_SEL_MEM;
        state_next = S_EX;
      end
      S_EX: begin
        ac_load_d    = 1'b1;
        nz_load_d    = 1'b1;
        sel_ula_d    = ula_for_op(opcode);
        instr_done_d = 1'b1;
        state_next   = S_F0;
      end
      S_S0: begin
        rdm_load_d = 1'b1;
        rdm_sel_d  = RDM_SEL_AC;
        state_next = S_S1;
      end
      S_S1: begin
        mem_write_d  = 1'b1;
        instr_done_d = 1'b1;
        state_next   = S_F0;
      end
      S_J: begin
        pc_load_d    = 1'b1;
        instr_done_d = 1'b1;
        state_next   = S_F0;
      end
      // Untaken conditional jump still has to step over its operand byte.
      S_SK: begin
        pc_inc_d     = 1'b1;
        instr_done_d = 1'b1;
        state_next   = S_F0;
      end
      S_NT: begin
        ac_load_d    = 1'b1;
        nz_load_d    = 1'b1;
        sel_ula_d    = ULA_NOT;
        instr_done_d = 1'b1;
        state_next   = S_F0;
      end
      S_H: begin
        halted_d   = 1'b1;
        state_next = S_H;
      end
      default: state_next = S_F0;
    endcase
  end

  assign pc_load    = rst & pc_load_d;
  assign pc_inc     = rst & pc_inc_d;
  assign rem_load   = rst & rem_load_d;
  assign rem_sel    = rst & rem_sel_d;
  assign rdm_load   = rst & rdm_load_d;
  assign rdm_sel    = rst & rdm_sel_d;
  assign mem_write  = rst & mem_write_d;
  assign ri_load    = rst & ri_load_d;
  assign ac_load    = rst & ac_load_d;
  assign sel_ula    = {3{rst}} & sel_ula_d;
  assign nz_load    = rst & nz_load_d;
  assign instr_done = rst & instr_done_d;
  assign halted     = rst & halted_d;

endmodule

// File: tb/tb_neander_control.sv
// Directed bench for neander_control driving a behavioural Neander datapath
// (16-bit words, opcode in bits [7:4], synchronous RAM read).
module tb_neander_control;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        flag_n;
  logic        flag_z;
  logic        pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel;
  logic        mem_write, ri_load, ac_load, nz_load, instr_done, halted;
  logic [2:0]  sel_ula;

  logic [7:0]  pc, rem;
  logic [15:0] rdm, ac, ram_q, ula;
  logic [3:0]  ri;
  logic [15:0] mem [256];

  logic        pk_en;
  logic [1:0]  pk_tgt;
  logic [7:0]  pk_addr;
  logic [15:0] pk_data;

  logic [14:0] outs;

  int checks;
  int errors;
  int total_conflicts;

  neander_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .rem_load   (rem_load),
    .rem_sel    (rem_sel),
    .rdm_load   (rdm_load),
    .rdm_sel    (rdm_sel),
    .mem_write  (mem_write),
    .ri_load    (ri_load),
    .ac_load    (ac_load),
    .sel_ula    (sel_ula),
    .nz_load    (nz_load),
    .instr_done (instr_done),
    .halted     (halted)
  );

  assign outs   = {pc_load, pc_inc, rem_load, rem_sel, rdm_load, rdm_sel, mem_write,
                   ri_load, ac_load, nz_load, instr_done, halted, sel_ula};
  assign opcode = ri;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ULA
  always_comb begin
    ula = rdm;
    case (sel_ula)
      3'b000:  ula = ac + rdm;
      3'b001:  ula = ac & rdm;
      3'b010:  ula = ac | rdm;
      3'b011:  ula = ~ac;
      default: ula = rdm;
    endcase
  end

  // Behavioural datapath registers and RAM; pk_* preloads state while idle.
  always @(posedge clk) begin
    ram_q <= mem[rem];
    if (pk_en) begin
      case (pk_tgt)
        2'd0:    mem[pk_addr] <= pk_data;
        2'd1:    pc <= pk_data[7:0];
        default: begin
          ac     <= pk_data;
          flag_n <= 1'b0;
          flag_z <= 1'b0;
          ri     <= 4'h0;
          rem    <= 8'h00;
          rdm    <= 16'h0000;
        end
      endcase
    end else begin
      if (pc_load)       pc <= rdm[7:0];
      else if (pc_inc)   pc <= pc + 8'd1;
      if (rem_load)      rem <= rem_sel ? rdm[7:0] : pc;
      if (rdm_load)      rdm <= rdm_sel ? ac : ram_q;
      if (mem_write)     mem[rem] <= rdm;
      if (ri_load)       ri <= rdm[7:4];
      if (ac_load)       ac <= ula;
      if (nz_load) begin
        flag_n <= ula[15];
        flag_z <= (ula == 16'h0000);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [1:0] tgt, input logic [7:0] addr, input logic [15:0] data);
    pk_en   = 1'b1;
    pk_tgt  = tgt;
    pk_addr = addr;
    pk_data = data;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Runs one instruction from F0 to its instr_done cycle, then steps into the next F0.
  task automatic applyStimulus(output int cycles, output int writes, output logic done,
                               output logic [2:0] ex_sel, output logic [7:0] wr_rem,
                               output logic [15:0] wr_rdm);
    cycles = 0;
    writes = 0;
    done   = 1'b0;
    ex_sel = 3'b111;
    wr_rem = 8'h00;
    wr_rdm = 16'h0000;
    for (int c = 0; c < 40; c++) begin
      cycles++;
      if ((pc_load && pc_inc) || (mem_write && rdm_load)) total_conflicts++;
      if (mem_write) begin
        writes++;
        wr_rem = rem;
        wr_rdm = rdm;
      end
      if (ac_load) ex_sel = sel_ula;
      if (instr_done) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string tag, input int exp_cycles, input logic [7:0] exp_pc);
    int          cyc, wr;
    logic        dn;
    logic [2:0]  es;
    logic [7:0]  wrem;
    logic [15:0] wrdm;
    applyStimulus(cyc, wr, dn, es, wrem, wrdm);
    checkOutput({tag, "_done"}, dn, 1'b1);
    checkOutput({tag, "_cycles"}, cyc, exp_cycles);
    checkOutput({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    int          cyc, wr, strobes;
    logic        dn;
    logic [2:0]  es;
    logic [7:0]  wrem;
    logic [15:0] wrdm;

    checks = 0;
    errors = 0;
    total_conflicts = 0;
    rst    = 1'b0;
    pk_en  = 1'b0;
    pk_tgt = 2'd0;
    pk_addr = 8'h00;
    pk_data = 16'h0000;

    step(2);
    poke(2'd1, 8'h00, 16'h0000);
    poke(2'd2, 8'h00, 16'h0000);
    poke(2'd0, 8'h00, 16'h0000);
    poke(2'd0, 8'h01, 16'h0020);
    poke(2'd0, 8'h02, 16'h0080);
    poke(2'd0, 8'h03, 16'h0030);
    poke(2'd0, 8'h04, 16'h0081);
    poke(2'd0, 8'h05, 16'h00A0);
    poke(2'd0, 8'h06, 16'h0010);
    poke(2'd0, 8'h10, 16'h0090);
    poke(2'd0, 8'h11, 16'h0020);
    poke(2'd0, 8'h12, 16'h0020);
    poke(2'd0, 8'h13, 16'h0082);
    poke(2'd0, 8'h14, 16'h0010);
    poke(2'd0, 8'h15, 16'h0090);
    poke(2'd0, 8'h16, 16'h0060);
    poke(2'd0, 8'h17, 16'h0070);
    poke(2'd0, 8'h18, 16'h0090);
    poke(2'd0, 8'h19, 16'h0030);
    poke(2'd0, 8'h30, 16'h0040);
    poke(2'd0, 8'h31, 16'h0083);
    poke(2'd0, 8'h32, 16'h0050);
    poke(2'd0, 8'h33, 16'h0084);
    poke(2'd0, 8'h34, 16'h0080);
    poke(2'd0, 8'h35, 16'h0040);
    poke(2'd0, 8'h40, 16'h0030);
    poke(2'd0, 8'h41, 16'h0081);
    poke(2'd0, 8'h42, 16'h0030);
    poke(2'd0, 8'h43, 16'h0081);
    poke(2'd0, 8'h44, 16'h00F0);
    poke(2'd0, 8'h45, 16'h0000);
    poke(2'd0, 8'h80, 16'h0005);
    poke(2'd0, 8'h81, 16'hFFFB);
    poke(2'd0, 8'h82, 16'h1234);
    poke(2'd0, 8'h83, 16'h0030);
    poke(2'd0, 8'h84, 16'h00FF);
    poke(2'd0, 8'h90, 16'h0000);

    checkOutput("reset_outs", outs, 15'h0000);
    rst = 1'b1;
    #1;
    checkOutput("first_f0", outs, 15'h1000);

    run_instr("nop", 5, 8'h01);

    applyStimulus(cyc, wr, dn, es, wrem, wrdm);
    checkOutput("lda_cycles", cyc, 12);
    checkOutput("lda_ex_sel", es, 3'b100);
    checkOutput("lda_ac", ac, 16'h0005);
    checkOutput("lda_nz", {flag_n, flag_z}, 2'b00);
    checkOutput("lda_pc", pc, 8'h03);

    run_instr("add", 12, 8'h05);
    checkOutput("add_ac", ac, 16'h0000);
    checkOutput("add_nz", {flag_n, flag_z}, 2'b01);

    run_instr("jz_taken", 9, 8'h10);
    run_instr("jn_skip", 6, 8'h12);
    run_instr("lda2", 12, 8'h14);
    checkOutput("lda2_ac", ac, 16'h1234);

    applyStimulus(cyc, wr, dn, es, wrem, wrdm);
    checkOutput("sta_cycles", cyc, 11);
    checkOutput("sta_writes", wr, 1);
    checkOutput("sta_rem", wrem, 8'h90);
    checkOutput("sta_rdm", wrdm, 16'h1234);
    checkOutput("sta_mem", mem[8'h90], 16'h1234);
    checkOutput("sta_pc", pc, 8'h16);

    run_instr("not", 6, 8'h17);
    checkOutput("not_ac", ac, 16'hEDCB);
    checkOutput("not_nz", {flag_n, flag_z}, 2'b10);

    run_instr("unknown", 5, 8'h18);
    checkOutput("unknown_ac", ac, 16'hEDCB);

    run_instr("jn_taken", 9, 8'h30);
    run_instr("or", 12, 8'h32);
    checkOutput("or_ac", ac, 16'hEDFB);
    run_instr("and", 12, 8'h34);
    checkOutput("and_ac", ac, 16'h00FB);
    checkOutput("and_nz", {flag_n, flag_z}, 2'b00);
    run_instr("jmp", 9, 8'h40);
    run_instr("add2", 12, 8'h42);
    checkOutput("add2_ac", ac, 16'h00F6);

    // ADD interrupted by reset in its A4 wait state
    step(8);
    checkOutput("mid_a3_outs", outs, 15'h1800);
    step(1);
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_outs", outs, 15'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_release_f0", outs, 15'h1000);
    checkOutput("mid_ac_kept", ac, 16'h00F6);
    checkOutput("mid_pc", pc, 8'h44);

    // HLT: enters H after decode and stays quiet
    step(5);
    checkOutput("hlt_halted", halted, 1'b1);
    checkOutput("hlt_pc", pc, 8'h45);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      if ((outs & ~15'h0008) != 15'h0000) strobes++;
      if (!halted) strobes++;
      step(1);
    end
    checkOutput("hlt_strobes", strobes, 0);
    checkOutput("hlt_pc_frozen", pc, 8'h45);

    rst = 1'b0;
    #1;
    checkOutput("hlt_reset_outs", outs, 15'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("hlt_resume_f0", outs, 15'h1000);
    run_instr("resume_nop", 5, 8'h46);

    checkOutput("strobe_conflicts", total_conflicts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neander_control.md
# neander_control

Control unit for the Neander processor: a Moore FSM that sits directly upstream of the datapath and drives every load/strobe/select it exposes (PC, REM, RAM, RDM, RI, AC, ULA, N/Z flags). It sequences fetch, decode and execute for the full Neander ISA from the 4-bit opcode held in RI and the registered N/Z flags. It replaces the constant tie-offs currently on the datapath control nets.

## Interface
Parameters: none. Encodings are fixed in `neander_pkg`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `opcode`  in  4  RI output
- `flag_n`, `flag_z`  in  1 each  registered N/Z flags from the datapath
- `pc_load`  out  1  PC ← RDM[7:0]
- `pc_inc`  out  1  PC ← PC+1
- `rem_load`  out  1  REM ← selected source
- `rem_sel`  out  1  REM source: 0 = PC, 1 = RDM[7:0]
- `rdm_load`  out  1  RDM ← selected source
- `rdm_sel`  out  1  RDM source: 0 = memory, 1 = AC
- `mem_write`  out  1  RAM write at REM with RDM
- `ri_load`  out  1  RI ← RDM opcode
- `ac_load`  out  1  AC ← ULA result
- `sel_ula`  out  3  ULA operation
- `nz_load`  out  1  N/Z ← ULA flags
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction
- `halted`  out  1  high while in HLT

## Operation
- ISA: NOP 0000, STA 0001, LDA 0010, ADD 0011, OR 0100, AND 0101, NOT 0110, JMP 1000, JN 1001, JZ 1010, HLT 1111. All other opcodes execute as NOP.
- ULA codes: ADD 000, AND 001, OR 010, NOT 011, PASSY 100. LDA uses PASSY.
- RAM read is synchronous: data is valid one cycle after REM is loaded, so every read has a wait state.
- States and asserted outputs:
  - F0 `rem_load`, `rem_sel`=0
  - F1 wait
  - F2 `rdm_load`, `rdm_sel`=0, `pc_inc`
  - F3 `ri_load`
  - DEC dispatch:
    - NOP/unknown → F0 with `instr_done`
    - NOT → NT
    - HLT → H
    - JN when N=0, JZ when Z=0 → SK
    - all other opcodes → A0
  - A0 `rem_load`, `rem_sel`=0
  - A1 wait
  - A2 `rdm_load`, `pc_inc`. Next: JMP/JN/JZ → J; STA, LDA, ADD, OR, AND → A3
  - A3 `rem_load`, `rem_sel`=1. Next: STA → S0, else → A4
  - A4 wait
  - A5 `rdm_load`, `rdm_sel`=0
  - EX `ac_load`, `nz_load`, `sel_ula` per opcode, `instr_done`
  - S0 `rdm_load`, `rdm_sel`=1
  - S1 `mem_write`, `instr_done`
  - J `pc_load`, `instr_done`
  - SK `pc_inc`, `instr_done` (skips the operand byte)
  - NT `ac_load`, `nz_load`, `sel_ula`=NOT, `instr_done`
  - H `halted`; remains in H until reset
- Every execute state not listed above returns to F0.
- `sel_ula` = 000 in every state except EX and NT.
- Flags are sampled only in DEC. The opcode is sampled only in DEC, A2, A3 and EX; RI is stable throughout because it loads only in F3.

## Timing
- Reset: while `rst`=0 at a rising edge, state ← F0. While `rst` is low, all outputs are forced to 0 (gated), including during reset mid-instruction. The first F0 cycle is the first cycle with `rst` high.
- Cycles per instruction, counting F0 through the `instr_done` cycle:
  - NOP 5
  - NOT 6
  - JN/JZ not taken 6
  - JMP and taken JN/JZ 9
  - STA 11
  - LDA/ADD/OR/AND 12
- `pc_load` and `pc_inc` are never asserted together. `mem_write` and `rdm_load` are never asserted together.
- `instr_done` is high in exactly one cycle per instruction and is never high in H.

## Structure
- `neander_pkg`: opcode enum, ULA op enum, state enum, `rem_sel`/`rdm_sel` constants.
- One module containing a state register plus a combinational next-state/output decode. No sub-module is needed.

## Test plan
Each case uses a behavioural datapath model.
- Reset, then PC=0, mem[0]=NOP(0x00): F0 rem_load at cycle 0; `instr_done` at cycle 4; PC=1.
- LDA 0x80 with mem[0x80]=0x0005: AC=5, N=0, Z=0 after 12 cycles; PC=2; `sel_ula`=100 in EX.
- LDA 0x80 (0x0005), ADD 0x81 (0xFFFB): AC=0, Z=1. Then JZ 0x10: PC=0x10 after 9 cycles. JN 0x20 with N=0: PC advances by 2 in 6 cycles.
- STA 0x90 with AC=0x1234: exactly one `mem_write` cycle, REM=0x90, RDM=0x1234; mem[0x90]=0x1234; 11 cycles.
- Opcode 0111 (unknown) behaves as NOP. HLT: `halted`=1, PC frozen, no strobes for 20 cycles; after `rst`=0 for one cycle, execution resumes from F0.
- Assert `rst`=0 during A4 of an ADD: all outputs 0 in that cycle; F0 is the first state after release; AC is unchanged.
